// File: rtl/matrix_memory_responder.sv
// matrix_memory_responder: memory-side responder for the matrix processor's
// start/done handshake. Owns a DEPTH x 16-bit store, clears it after reset,
// then services one read or write per handshake with a fixed LATENCY.
//
// Handshake: the initiator raises mem_start with address/data/write-enable
// and holds it. The request is accepted on the first IDLE edge that sees
// mem_start = 1. mem_done rises LATENCY edges later and stays high until an
// edge samples mem_start = 0. mem_data_out and mem_error are valid while
// mem_done = 1.
//
// Optional feature macro: MATRIX_MEM_PARITY_EN adds an even-parity bit per
// word and the mem_parity_inject input for corrupting a stored parity bit.
module matrix_memory_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_start,
   input  logic        mem_write_enabled,
   input  logic [5:0]  mem_address,
   input  logic [15:0] mem_data_in,
`ifdef MATRIX_MEM_PARITY_EN
   input  logic        mem_parity_inject,
`endif
   output logic [15:0] mem_data_out,
   output logic        mem_done,
   output logic        mem_ready,
   output logic        mem_error,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_IDLE   = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

`ifdef MATRIX_MEM_PARITY_EN
   localparam int WW = 17;
`else
   localparam int WW = 16;
`endif
   localparam int             CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [6:0]     DEPTH_L   = 7'(DEPTH);
   localparam logic [5:0]     LAST_ADDR = 6'(DEPTH - 1);
   localparam logic [CW-1:0]  LAT_LOAD  = CW'(LATENCY - 1);

   state_t            state_q, state_d;
   logic [5:0]        clear_addr_q, clear_addr_d;
   logic [CW-1:0]     lat_cnt_q, lat_cnt_d;
   logic [5:0]        addr_q, addr_d;
   logic              we_q, we_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [15:0]       data_out_q, data_out_d;
   logic              error_q, error_d;
`ifdef MATRIX_MEM_PARITY_EN
   logic              inj_q, inj_d;
`endif

   logic [WW-1:0]     mem_q [DEPTH];

   logic              in_range;
   logic [5:0]        rd_idx;
   logic [WW-1:0]     rd_word;
   logic              arr_we;
   logic [5:0]        arr_waddr;
   logic [WW-1:0]     arr_wdata;

   // Range check and array read of the latched request address.
   assign in_range = ({1'b0, addr_q} < DEPTH_L);
   assign rd_idx   = in_range ? addr_q : 6'd0;
   assign rd_word  = mem_q[rd_idx];

   // State and request registers; reset aborts everything and restarts the clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_INIT;
         clear_addr_q <= 6'd0;
         lat_cnt_q    <= '0;
         addr_q       <= 6'd0;
         we_q         <= 1'b0;
         wdata_q      <= 16'h0000;
         data_out_q   <= 16'h0000;
         error_q      <= 1'b0;
`ifdef MATRIX_MEM_PARITY_EN
         inj_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         clear_addr_q <= clear_addr_d;
         lat_cnt_q    <= lat_cnt_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         data_out_q   <= data_out_d;
         error_q      <= error_d;
`ifdef MATRIX_MEM_PARITY_EN
         inj_q        <= inj_d;
`endif
      end
   end

   // Next-state logic: clear walk, acceptance, latency countdown, commit, release.
   always_comb begin
      state_d      = state_q;
      clear_addr_d = clear_addr_q;
      lat_cnt_d    = lat_cnt_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      data_out_d   = data_out_q;
      error_d      = error_q;
`ifdef MATRIX_MEM_PARITY_EN
      inj_d        = inj_q;
`endif
      case (state_q)
         S_INIT: begin
            clear_addr_d = clear_addr_q + 6'd1;
            if (clear_addr_q == LAST_ADDR) begin
               clear_addr_d = 6'd0;
               state_d      = S_IDLE;
            end
         end
         S_IDLE: begin
            if (mem_start) begin
               addr_d    = mem_address;
               we_d      = mem_write_enabled;
               wdata_d   = mem_data_in;
`ifdef MATRIX_MEM_PARITY_EN
               inj_d     = mem_parity_inject;
`endif
               lat_cnt_d = LAT_LOAD;
               state_d   = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (lat_cnt_q != '0) begin
               lat_cnt_d = lat_cnt_q - CW'(1);
            end else begin
               state_d = S_DONE;
               error_d = !in_range;
               if (!we_q) begin
                  data_out_d = in_range ? rd_word[15:0] : 16'h0000;
`ifdef MATRIX_MEM_PARITY_EN
                  if (in_range && (^rd_word)) error_d = 1'b1;
`endif
               end
            end
         end
         S_DONE: begin
            if (!mem_start) begin
               error_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // Array write port: clear words during INIT, in-range writes at commit.
   always_comb begin
      arr_we    = 1'b0;
      arr_waddr = clear_addr_q;
      arr_wdata = '0;
      if (!reset) begin
         if (state_q == S_INIT) begin
            arr_we = 1'b1;
         end else if (state_q == S_ACCESS && lat_cnt_q == '0 && we_q && in_range) begin
            arr_we    = 1'b1;
            arr_waddr = addr_q;
`ifdef MATRIX_MEM_PARITY_EN
            arr_wdata = {(^wdata_q) ^ inj_q, wdata_q};
`else
            arr_wdata = wdata_q;
`endif
         end
      end
   end

   // Storage array; contents are defined by the INIT clear, not by reset.
   always_ff @(posedge clock) begin
      if (arr_we) mem_q[arr_waddr] <= arr_wdata;
   end

   // Outputs decoded from state and registered response.
   always_comb begin
      mem_done     = (state_q == S_DONE);
      mem_ready    = (state_q != S_INIT);
      mem_error    = error_q;
      mem_data_out = data_out_q;
      dbg_state_o  = state_q;
   end

endmodule

// File: doc/matrix_memory_responder.md
# matrix_memory_responder

Memory-side responder for the matrix processor's start/done memory handshake. It owns the 64-word × 16-bit data store that holds the instruction-addressed words and the packed 5×5 matrix buffers (buffer `id` × 13 + word index, two 8-bit elements per word). It services one read or write per handshake with a fixed, parameterised access latency. It sits between the control unit's `mem_*` outputs and the storage array.

## Interface
Parameters:
- `DEPTH`, 64: number of implemented words, 1..64. Addresses ≥ `DEPTH` are out of range.
- `LATENCY`, 2: cycles from accepting a request to committing it, ≥ 1.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_start`  in  1  request; level-held by the initiator until it sees `mem_done`.
- `mem_write_enabled`  in  1  1 = write, 0 = read; sampled at acceptance.
- `mem_address`  in  6  word address; sampled at acceptance.
- `mem_data_in`  in  16  write data; sampled at acceptance.
- `mem_data_out`  out  16  read data; valid while `mem_done` = 1 on a read.
- `mem_done`  out  1  completion; held until `mem_start` falls.
- `mem_ready`  out  1  1 once the post-reset clear has finished.
- `mem_error`  out  1  error status; valid while `mem_done` = 1.

## Operation
- States: INIT, IDLE, ACCESS, DONE.
- **INIT** (entered on `reset`):
  - Walks `clear_addr` from 0 to `DEPTH`-1, writing 0x0000, one word per cycle.
  - `mem_ready` = 0 throughout; `mem_start` is ignored, so a held request simply waits.
  - After the write to `DEPTH`-1, go to IDLE and set `mem_ready` = 1.
- **IDLE**:
  - If `mem_start` = 1, latch the address, write-enable and data, load `lat_cnt` = `LATENCY`-1, and go to ACCESS.
- **ACCESS**:
  - While `lat_cnt` ≠ 0, decrement it.
  - When `lat_cnt` = 0, commit the request and go to DONE with `mem_done` = 1.
  - Commit for a write: store the latched data.
  - Commit for a read: register the array word into `mem_data_out`.
- **DONE**:
  - Hold `mem_done`, `mem_data_out` and `mem_error` for as long as `mem_start` = 1.
  - On the first edge that sees `mem_start` = 0: `mem_done` goes to 0, `mem_error` goes to 0, go to IDLE.
  - `mem_data_out` keeps the last read value.
- **Out of range** (latched address ≥ `DEPTH`):
  - Full handshake still completes.
  - A write changes nothing.
  - A read returns 0x0000.
  - `mem_error` = 1 with `mem_done`.
- Request inputs that change after acceptance are ignored until the next IDLE acceptance.
- Only one request is outstanding at a time; there is no queueing.

## Timing
- Reset values:
  - `mem_done` = 0, `mem_ready` = 0, `mem_error` = 0, `mem_data_out` = 0x0000.
  - State = INIT, `clear_addr` = 0.
- `mem_ready` rises `DEPTH` edges after the first edge with `reset` = 0.
- Latency: `mem_start` sampled 1 in IDLE at edge E0 ⇒ `mem_done` = 1 after edge E0+`LATENCY`. With `LATENCY` = 1, the first ACCESS edge commits.
- A write is visible to any read accepted after its DONE.
- Release and back-to-back requests:
  - `mem_done` falls one edge after `mem_start` is sampled 0.
  - The earliest next acceptance is the following edge (IDLE).
  - For an initiator that drops `mem_start` the cycle after seeing `mem_done` and re-raises it one cycle later, the per-word period is `LATENCY`+3 cycles.
- Reset mid-operation:
  - Aborts the operation immediately; `mem_done` = 0.
  - An uncommitted write is discarded.
  - INIT clears the whole array regardless of prior contents.
- `reset` and `mem_start` both high: reset wins.

## Configuration
- `MATRIX_MEM_PARITY_EN` defined:
  - Each word stores 17 bits: data plus an even-parity bit.
  - Adds input port `mem_parity_inject` (1 bit). When it is 1 at acceptance of a write, the stored parity bit is inverted.
  - On a read, a parity mismatch sets `mem_error` = 1 with `mem_done`, and the stored data is still returned.
  - INIT writes parity 0.
- Macro undefined:
  - 16-bit storage, no `mem_parity_inject` port.
  - `mem_error` is set only by out-of-range addresses.

## Test plan
- Reset released, `DEPTH` = 64 → `mem_ready` = 0 for 64 cycles then 1; read of address 10 returns 0x0000 with `mem_error` = 0.
- Write 0xA5C3 to address 13, `LATENCY` = 2, `mem_start` held 5 cycles → `mem_done` rises exactly 2 edges after acceptance, stays 1 while `mem_start` = 1, and falls one edge after `mem_start` = 0; a read of address 13 returns 0xA5C3.
- Initiator-style burst: write 13 words 0x0101·k to addresses 26, 27 … 38, then read them back → every value matches; period `LATENCY`+3 cycles per word.
- `DEPTH` = 39: write 0xFFFF to address 40, then read address 40 → both complete with `mem_error` = 1; read data is 0x0000; addresses 0–38 are unchanged.
- Write 0x1234 to address 5, then assert `reset` during ACCESS → `mem_done` = 0 next edge; after `mem_ready` returns, address 5 reads 0x0000.
- With `MATRIX_MEM_PARITY_EN`: write 0x00FF to address 3 with `mem_parity_inject` = 1, then read it → `mem_data_out` = 0x00FF, `mem_error` = 1. The same sequence with inject = 0 gives `mem_error` = 0.
